// File: rtl/fetch_unit.sv
// fetch_unit: PC register, 2-entry fetch buffer, reset/run/halt FSM.
// Optional FETCH_MISALIGN_CHECK_EN: sticky fault on misaligned redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        halted,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] e_pc_q  [2];
  logic [31:0] e_ins_q [2];
  logic        push, pop, flush;
  logic        full, has;
  logic        fault_q, misalign;
  logic [1:0]  wsel;

  assign full = (cnt_q == 2'(BUF_DEPTH));
  assign has  = (cnt_q != 2'd0);
  assign wsel = cnt_q - {1'b0, pop};

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = (redirect_pc[1:0] != 2'b00);

  // Fault latches on a misaligned redirect and only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (redirect_valid && state_q != S_RESET && misalign) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign misalign = 1'b0;
  assign fault_q  = 1'b0;
`endif

  // State, pc and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, push/pop/flush decisions; redirect wins over all else
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    pop     = if_valid && if_ready;
    unique case (state_q)
      S_RESET: state_d = S_RUN;
      S_RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = redirect_pc;
          if (halt_req || misalign) state_d = S_HALT;
        end else if (halt_req) begin
          state_d = S_HALT;
        end else begin
          push = !full || pop;
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = redirect_pc;
        end else if (!halt_req && !fault_q) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RESET;
    endcase
    if (push) pc_d = pc_q + 32'd4;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Shift-style buffer: entry 0 is always the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_pc_q[0]  <= '0;
      e_pc_q[1]  <= '0;
      e_ins_q[0] <= '0;
      e_ins_q[1] <= '0;
    end else begin
      if (push && wsel == 2'd0) begin
        e_pc_q[0]  <= pc_q;
        e_ins_q[0] <= imem_instr;
      end else if (pop) begin
        e_pc_q[0]  <= e_pc_q[1];
        e_ins_q[0] <= e_ins_q[1];
      end
      if (push && wsel == 2'd1) begin
        e_pc_q[1]  <= pc_q;
        e_ins_q[1] <= imem_instr;
      end
    end
  end

  assign imem_pc     = pc_q;
  assign if_valid    = has && !redirect_valid;
  assign if_pc       = has ? e_pc_q[0] : '0;
  assign if_instr    = has ? e_ins_q[0] : '0;
  assign if_pc4      = has ? e_pc_q[0] + 32'd4 : '0;
  assign halted      = (state_q == S_HALT) && !has;
  assign fetch_fault = fault_q;

endmodule
